multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter ILLEGAL_TRAP, default 1; 1 = unknown opcode/funct enters ILLEGAL; 0 = treated as NOP (return to FETCH).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  in  6  instruction bits [31:26], from instruction register.
REQ-005 SHALL have port funct  in  6  instruction bits [5:0], from instruction register.
REQ-006 SHALL have port zero  in  1  1 when ALU result == 0.
REQ-007 SHALL have port mem_ready  in  1  memory handshake; 1 = access completes this cycle.
REQ-008 SHALL have ports pc_write, ir_write, reg_write, mem_write  out  1 each  register/memory enables.
REQ-009 SHALL have ports iord, reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath mux selects.
REQ-010 SHALL have ports alu_src_b, pc_src  out  2 each  mux selects (src_b: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2; pc_src: 00 ALU, 01 ALUOut, 10 jump target).
REQ-011 SHALL have port alu_op  out  4  ALU code: ADD 0000, SUB 0010, AND 0100, OR 0101, XOR 0110, NOR 0111, SLT 1010.
REQ-012 SHALL have ports illegal  out  1  (sticky trap flag) and state  out  4  (current state, debug).

Function
REQ-013 SHALL be an FSM, states: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 12.
REQ-014 SHALL drive every output not listed for a state to 0 (alu_op to ADD).
REQ-015 FETCH: iord=0, src_a=0, src_b=01, ADD, pc_src=00; ir_write=pc_write=1 only in the cycle mem_ready=1; stay in FETCH while mem_ready=0, else -> DECODE.
REQ-016 DECODE: src_a=0, src_b=11, ADD; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, other -> ILLEGAL (ILLEGAL_TRAP=1) or FETCH.
REQ-017 MEMADR: src_a=1, src_b=10, ADD; -> MEMRD if lw, MEMWR if sw.
REQ-018 MEMRD: iord=1; hold until mem_ready=1, then -> MEMWB. MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; -> FETCH.
REQ-019 MEMWR: iord=1, mem_write=1 held every cycle until mem_ready=1; -> FETCH that cycle.
REQ-020 EXEC: src_a=1, src_b=00, alu_op from funct (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT); -> ALUWB; unknown funct -> ILLEGAL/FETCH per ILLEGAL_TRAP, reg_write never asserted.
REQ-021 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; -> FETCH.
REQ-022 BRANCH: src_a=1, src_b=00, SUB, pc_src=01, pc_write=zero (same cycle); -> FETCH.
REQ-023 ADDIEX: src_a=1, src_b=10, ADD; -> ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; -> FETCH.
REQ-024 JUMP: pc_src=10, pc_write=1; -> FETCH.
REQ-025 ILLEGAL: illegal=1, all enables 0; remain until reset.
REQ-026 Latency (mem_ready=1 always): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-027 reset=1 at a clock edge SHALL force FETCH and clear illegal, overriding any transition, including mid-access wait states.
REQ-028 During the reset cycle and the cycle after, SHALL assert no write enable (pc_write, ir_write, reg_write, mem_write) while mem_ready=0.

Structure
REQ-029 Package mc_pkg SHALL hold state encodings, opcode/funct constants and ALU op codes (shared with the ALU).
REQ-030 Funct->alu_op decode SHALL be a combinational sub-module alu_decoder; FSM stays in multicycle_control.

Verification
REQ-031 reset, then R-type add (opcode 0, funct 100000), mem_ready=1 -> states 0,1,6,7,0; alu_op 0000 in EXEC; reg_write=1, reg_dst=1 only in ALUWB.
REQ-032 lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1, reg_write=1 exactly one cycle.
REQ-033 beq with zero=1 then zero=0 -> pc_write=1, pc_src=01 in BRANCH only for zero=1; both return to FETCH.
REQ-034 opcode 111111, ILLEGAL_TRAP=1 -> state 12, illegal=1 sticky; reset -> state 0, illegal=0. ILLEGAL_TRAP=0 -> DECODE->FETCH, illegal stays 0.
REQ-035 reset asserted in MEMWR with mem_ready=0 -> next state FETCH, mem_write=0 from that edge.
REQ-036 R-type, funct 101010 -> alu_op 1010; funct 000000 -> no reg_write, ILLEGAL per parameter.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller and the ALU it steers.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_NOR = 4'b0111,
    ALU_SLT = 4'b1010
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU B operand mux selects
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source mux selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation decode; flags functs it does not know.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       known
);

  // Pure lookup; unknown functs fall back to ADD with known cleared
  always_comb begin
    alu_op = ALU_ADD;
    known  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_XOR:  alu_op = ALU_XOR;
      FN_NOR:  alu_op = ALU_NOR;
      FN_SLT:  alu_op = ALU_SLT;
      default: known  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch, decode and the
// per-instruction execute/memory/writeback steps, with a memory handshake.
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t  state_q, state_d;
  logic    illegal_q, illegal_d;
  alu_op_t dec_op;
  logic    dec_known;

  alu_decoder u_alu_decoder (
    .funct  (funct),
    .alu_op (dec_op),
    .known  (dec_known)
  );

  // Where an unrecognised opcode/funct goes
  state_t bad_target;
  assign bad_target = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;

  // State and sticky trap flag; reset wins over any pending transition
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore/Mealy control outputs for the current state
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = bad_target;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = dec_op;
        state_d   = dec_known ? S_ALUWB : bad_target;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_write  = zero;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_ILLEGAL);
    // The register is not yet in FETCH during the reset cycle, so a pending
    // access (e.g. a store waiting on mem_ready) must not leak a write.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
